// File: rtl/gecko_run_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gecko_run_sequencer_pkg
//   Shared types and constants for the gecko run sequencer.
//   - gecko_run_seq_state_t : sequencer FSM states
//   - GECKO_RUN_SEQ_FLAG_MASK_CYCLES : RUN cycles during which the core's
//     finished/faulted flags are ignored (flags may be stale right after reset)
//   - helpers for the saturating 16-bit counters and core-reset decode
// -----------------------------------------------------------------------------
package gecko_run_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HOLD,
    RUN,
    RD_REQ,
    RD_RESP,
    WR_REQ,
    WR_RESP,
    CHECK,
    DONE
  } gecko_run_seq_state_t;

  localparam int unsigned GECKO_RUN_SEQ_FLAG_MASK_CYCLES = 2;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [15:0] gecko_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The core must be out of reset while running and while its memory is
  // accessed, since the supervisor port reaches memory through the core.
  function automatic logic gecko_core_active(input gecko_run_seq_state_t s);
    return (s == RUN) || (s == RD_REQ) || (s == RD_RESP) ||
           (s == WR_REQ) || (s == WR_RESP);
  endfunction

endpackage

// File: rtl/gecko_run_sequencer.sv
// -----------------------------------------------------------------------------
// gecko_run_sequencer
//   Supervisor-side controller that runs a program on gecko_micro repeatedly.
//   Each run: hold core in reset for RESET_CYCLES, release it, wait for
//   finished_flag/faulted_flag. On finish, read the result word at
//   RESULT_ADDR and write it back to SEED_ADDR for the next run.
//
//   Optional build macro: GECKO_RUN_SEQ_TIMEOUT_EN
//     defined   : watchdog of TIMEOUT_CYCLES in RUN; expiry is treated as a
//                 fault and sets the sticky timed_out flag.
//     undefined : RUN waits indefinitely; timed_out is constant 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, num_runs     begin a sequence (IDLE/DONE only); 0 runs = unlimited
//   core_rst            reset into gecko_micro
//   finished_flag,
//   faulted_flag        run status from the core
//   req_*               supervisor std_mem request channel
//   resp_*              supervisor std_mem response channel
//   busy, done          status (busy outside IDLE/DONE, done in DONE)
//   result,
//   result_valid        last captured result word, one-cycle update pulse
//   run_count,
//   fault_count         completed runs / faulted runs (saturating)
//   timed_out           last fault came from the watchdog (sticky)
// -----------------------------------------------------------------------------
module gecko_run_sequencer
  import gecko_run_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] SEED_ADDR      = '0,
  parameter int unsigned           RESET_CYCLES   = 20,
  parameter int unsigned           TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             num_runs,
  output logic                    core_rst,
  input  logic                    finished_flag,
  input  logic                    faulted_flag,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_read_enable,
  output logic [DATA_WIDTH/8-1:0] req_write_enable,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_data,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  input  logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    result_valid,
  output logic [15:0]             run_count,
  output logic [15:0]             fault_count,
  output logic                    timed_out
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam int unsigned MASK_W = $clog2(GECKO_RUN_SEQ_FLAG_MASK_CYCLES + 1);
  localparam logic [MASK_W-1:0] MASK_DONE = MASK_W'(GECKO_RUN_SEQ_FLAG_MASK_CYCLES);

  gecko_run_seq_state_t state_q, state_d;

  logic [HOLD_W-1:0]       hold_cnt_q;
  logic [MASK_W-1:0]       mask_cnt_q;
  logic [15:0]             num_runs_q;
  logic [15:0]             run_count_q;
  logic [15:0]             fault_count_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    result_valid_q;

  logic                    core_rst_q;
  logic                    req_valid_q;
  logic                    req_read_enable_q;
  logic [DATA_WIDTH/8-1:0] req_write_enable_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_data_q;
  logic                    resp_ready_q;
  logic                    busy_q;
  logic                    done_q;

  logic start_ok;
  logic flags_live;
  logic real_fault;
  logic timeout_hit;
  logic run_fault;
  logic rd_capture;

  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign flags_live = (mask_cnt_q == MASK_DONE);
  assign real_fault = (state_q == RUN) && flags_live && faulted_flag;
  assign run_fault  = real_fault || timeout_hit;
  assign rd_capture = (state_q == RD_RESP) && resp_valid;

`ifdef GECKO_RUN_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic            timed_out_q;

  assign timeout_hit = (state_q == RUN) && (wd_q == WD_LAST);
  assign timed_out   = timed_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q        <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wd_q <= (state_q == RUN) ? wd_q + WD_W'(1) : '0;
      if (start_ok) begin
        timed_out_q <= 1'b0;
      end else if (timeout_hit && !real_fault) begin
        timed_out_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = HOLD;
      HOLD:       if (hold_cnt_q == HOLD_LAST) state_d = RUN;
      RUN: begin
        // Fault (or watchdog) takes priority over a simultaneous finish.
        if (run_fault)                        state_d = CHECK;
        else if (flags_live && finished_flag) state_d = RD_REQ;
      end
      RD_REQ:     if (req_ready)  state_d = RD_RESP;
      RD_RESP:    if (resp_valid) state_d = WR_REQ;
      WR_REQ:     if (req_ready)  state_d = WR_RESP;
      WR_RESP:    if (resp_valid) state_d = CHECK;
      CHECK: begin
        if ((num_runs_q != 16'd0) && (run_count_q == num_runs_q)) state_d = DONE;
        else                                                       state_d = HOLD;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      hold_cnt_q         <= '0;
      mask_cnt_q         <= '0;
      num_runs_q         <= '0;
      run_count_q        <= '0;
      fault_count_q      <= '0;
      result_q           <= '0;
      result_valid_q     <= 1'b0;
      core_rst_q         <= 1'b1;
      req_valid_q        <= 1'b0;
      req_read_enable_q  <= 1'b0;
      req_write_enable_q <= '0;
      req_addr_q         <= '0;
      req_data_q         <= '0;
      resp_ready_q       <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= (state_q == HOLD) ? hold_cnt_q + HOLD_W'(1) : '0;

      if (state_q != RUN)  mask_cnt_q <= '0;
      else if (!flags_live) mask_cnt_q <= mask_cnt_q + MASK_W'(1);

      if (start_ok) begin
        num_runs_q    <= num_runs;
        run_count_q   <= '0;
        fault_count_q <= '0;
      end else if ((state_q == RUN) && run_fault) begin
        run_count_q   <= gecko_sat_inc16(run_count_q);
        fault_count_q <= gecko_sat_inc16(fault_count_q);
      end else if ((state_q == WR_RESP) && resp_valid) begin
        run_count_q   <= gecko_sat_inc16(run_count_q);
      end

      result_valid_q <= rd_capture;
      if (rd_capture) result_q <= resp_data;

      core_rst_q         <= !gecko_core_active(state_d);
      req_valid_q        <= (state_d == RD_REQ) || (state_d == WR_REQ);
      req_read_enable_q  <= (state_d == RD_REQ);
      req_write_enable_q <= (state_d == WR_REQ) ? '1 : '0;
      req_addr_q         <= (state_d == RD_REQ) ? RESULT_ADDR :
                            (state_d == WR_REQ) ? SEED_ADDR : '0;
      // Write data comes straight from the read response so it is valid on
      // the first WR_REQ cycle; it then holds until the handshake.
      if (rd_capture)              req_data_q <= resp_data;
      else if (state_d != WR_REQ)  req_data_q <= '0;
      resp_ready_q       <= (state_d == RD_RESP) || (state_d == WR_RESP);
      busy_q             <= (state_d != IDLE) && (state_d != DONE);
      done_q             <= (state_d == DONE);
    end
  end

  assign core_rst         = core_rst_q;
  assign req_valid        = req_valid_q;
  assign req_read_enable  = req_read_enable_q;
  assign req_write_enable = req_write_enable_q;
  assign req_addr         = req_addr_q;
  assign req_data         = req_data_q;
  assign resp_ready       = resp_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign result           = result_q;
  assign result_valid     = result_valid_q;
  assign run_count        = run_count_q;
  assign fault_count      = fault_count_q;

endmodule

// File: tb/tb_gecko_run_sequencer.sv
module tb_gecko_run_sequencer;

  localparam int unsigned RST_CYC    = 20;
  localparam int unsigned TO_CYC     = 100;
  localparam int unsigned MASK_CYC   = 2;
  localparam logic [31:0] RES_A      = 32'h0000_0000;
  localparam logic [31:0] SEED_A     = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_runs = '0;
  logic        core_rst;
  logic        finished_flag = 1'b0;
  logic        faulted_flag = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_read_enable;
  logic [3:0]  req_write_enable;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = '0;
  logic        busy, done, result_valid, timed_out;
  logic [31:0] result;
  logic [15:0] run_count, fault_count;

  always #5 clk = ~clk;

  gecko_run_sequencer #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .RESULT_ADDR   (RES_A),
    .SEED_ADDR     (SEED_A),
    .RESET_CYCLES  (RST_CYC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_runs(num_runs),
    .core_rst(core_rst), .finished_flag(finished_flag), .faulted_flag(faulted_flag),
    .req_valid(req_valid), .req_ready(req_ready), .req_read_enable(req_read_enable),
    .req_write_enable(req_write_enable), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .done(done), .result(result), .result_valid(result_valid),
    .run_count(run_count), .fault_count(fault_count), .timed_out(timed_out)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scenario knobs and per-sequence statistics shared with the models.
  logic [7:0]   fault_mask   = '0;
  int unsigned  finish_delay = 50;
  int unsigned  ready_delay  = 0;
  logic [31:0]  rd_base      = '0;
  int unsigned  rd_idx       = 0;
  logic [31:0]  last_rd      = '0;
  int unsigned  n_rd = 0, n_wr = 0, rv_pulses = 0, run_idx = 0;
  int unsigned  gaps[$];
  bit           gap_armed = 0;
  int unsigned  last_low_len = 0;
  bit           last_fire_read = 0;

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; rv_pulses = 0; run_idx = 0; rd_idx = 0;
    gaps.delete(); gap_armed = 0;
  endtask

  // Core model: raises a flag finish_delay cycles after release, holds it
  // until reset; also records core_rst high gaps between runs.
  initial begin
    int unsigned cyc, hi, lo;
    cyc = 0; hi = 0; lo = 0;
    forever begin
      @(negedge clk);
      if (core_rst) begin
        if (lo > 0) begin last_low_len = lo; lo = 0; end
        finished_flag = 1'b0; faulted_flag = 1'b0; cyc = 0; hi++;
      end else begin
        if (hi > 0) begin
          if (gap_armed) gaps.push_back(hi);
          gap_armed = 1; hi = 0; run_idx++;
        end
        cyc++; lo++;
        if (finish_delay != 0 && cyc == finish_delay) begin
          if (run_idx >= 1 && run_idx <= 8 && fault_mask[run_idx-1]) faulted_flag = 1'b1;
          else finished_flag = 1'b1;
        end
      end
    end
  end

  // Memory model: optional ready stall, one-cycle response, protocol checks.
  initial begin
    logic [68:0] snap;
    int unsigned wcnt;
    bit prev_wait, fired, resp_hs;
    wcnt = 0; prev_wait = 0; fired = 0; resp_hs = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_ready = 0; resp_valid = 0; wcnt = 0; prev_wait = 0; fired = 0; resp_hs = 0;
      end else begin
        if (resp_hs) begin resp_valid = 0; resp_hs = 0; end
        if (fired) begin
          fired = 0; req_ready = 0; resp_valid = 1;
          if (last_fire_read) begin
            resp_data = rd_base + rd_idx; last_rd = resp_data; rd_idx++;
          end else begin
            resp_data = $urandom;
          end
        end
        if (resp_valid && resp_ready) resp_hs = 1;
        if (prev_wait) begin
          chk("req_held", req_valid, 1);
          chk("req_stable", {31'd0, ({req_read_enable, req_write_enable, req_addr, req_data} == snap)}, 1);
        end
        if (req_valid) begin
          if (wcnt >= ready_delay) begin
            req_ready = 1; fired = 1; prev_wait = 0; wcnt = 0;
            last_fire_read = req_read_enable;
            if (req_read_enable) begin
              n_rd++;
              chk("rd_we", req_write_enable, 4'h0);
              chk("rd_addr", req_addr, RES_A);
            end else begin
              n_wr++;
              chk("wr_we", req_write_enable, 4'hF);
              chk("wr_addr", req_addr, SEED_A);
              chk("wr_data", req_data, last_rd);
            end
          end else begin
            req_ready = 0; wcnt++; prev_wait = 1;
            snap = {req_read_enable, req_write_enable, req_addr, req_data};
          end
        end else begin
          prev_wait = 0;
        end
      end
    end
  end

  // result_valid must pulse with the freshly read word on result.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        rv_pulses++;
        chk("rv_result", result, last_rd);
      end
    end
  end

  task automatic do_start(input logic [15:0] n);
    int unsigned cnt;
    @(negedge clk);
    num_runs = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    while (core_rst && cnt < 1000) begin @(negedge clk); cnt++; end
    chk("hold_len", cnt, RST_CYC);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk("done_reached", {31'd0, done}, 1);
  endtask

  typedef struct {
    logic [15:0] nr;
    logic [7:0]  fmask;
    int unsigned rdy;
    logic [31:0] base;
    int unsigned exp_rd;
    logic [15:0] exp_runs;
    logic [15:0] exp_faults;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int unsigned n;
    vecs[0] = '{16'd1, 8'h00, 0, 32'hDEADBEEF, 1, 16'd1, 16'd0, 32'hDEADBEEF};
    vecs[1] = '{16'd3, 8'h00, 0, 32'h0000_1000, 3, 16'd3, 16'd0, 32'h0000_1002};
    vecs[2] = '{16'd3, 8'h02, 0, 32'h0000_2000, 2, 16'd3, 16'd1, 32'h0000_2001};
    vecs[3] = '{16'd2, 8'h00, 5, 32'hA5A5_0000, 2, 16'd2, 16'd0, 32'hA5A5_0001};
    vecs[4] = '{16'd2, 8'h03, 0, 32'h0000_3000, 0, 16'd2, 16'd2, 32'hA5A5_0001};

    repeat (3) @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_run_count", run_count, 0);
    chk("rst_fault_count", fault_count, 0);
    chk("rst_timed_out", timed_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fault_mask = vecs[i].fmask; ready_delay = vecs[i].rdy; rd_base = vecs[i].base;
      finish_delay = 50;
      clear_stats();
      do_start(vecs[i].nr);
      wait_done(5000);
      @(negedge clk);
      chk("v_busy", busy, 0);
      chk("v_core_rst", core_rst, 1);
      chk("v_run_count", run_count, vecs[i].exp_runs);
      chk("v_fault_count", fault_count, vecs[i].exp_faults);
      chk("v_result", result, vecs[i].exp_res);
      chk("v_timed_out", timed_out, 0);
      chk("v_reads", n_rd, vecs[i].exp_rd);
      chk("v_writes", n_wr, vecs[i].exp_rd);
      chk("v_rv_pulses", rv_pulses, vecs[i].exp_rd);
      // Between runs core_rst covers the CHECK cycle plus the HOLD interval.
      chk("v_gap_count", gaps.size(), vecs[i].nr - 1);
      foreach (gaps[g]) chk("v_gap_len", gaps[g], RST_CYC + 1);
    end

    // Flags raised on the first RUN cycle are masked for MASK_CYC cycles.
    fault_mask = '0; ready_delay = 0; rd_base = 32'h77; finish_delay = 1;
    clear_stats();
    do_start(16'd1);
    n = 0;
    while (!req_valid && n < 100) begin @(negedge clk); n++; end
    chk("mask_latency", n, MASK_CYC + 1);
    wait_done(2000);
    chk("mask_result", result, 32'h77);

    // Unlimited runs; start while busy is ignored; reset during RD_RESP.
    finish_delay = 10; rd_base = 32'h5000;
    clear_stats();
    do_start(16'd0);
    n = 0;
    while (run_count < 2 && n < 2000) begin @(negedge clk); n++; end
    num_runs = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (run_count < 4 && n < 2000) begin @(negedge clk); n++; end
    chk("unl_run_count", run_count, 4);
    chk("unl_busy", busy, 1);
    chk("unl_done", done, 0);
    n = 0;
    while (!(resp_ready && last_fire_read) && n < 2000) begin @(negedge clk); n++; end
    chk("unl_in_rd_resp", resp_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_req_valid", req_valid, 0);
    chk("arst_resp_ready", resp_ready, 0);
    chk("arst_run_count", run_count, 0);
    chk("arst_fault_count", fault_count, 0);
    chk("arst_result", result, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef GECKO_RUN_SEQ_TIMEOUT_EN
    finish_delay = 0;
    clear_stats();
    do_start(16'd1);
    wait_done(2000);
    chk("to_timed_out", timed_out, 1);
    chk("to_fault_count", fault_count, 1);
    chk("to_run_count", run_count, 1);
    chk("to_reads", n_rd, 0);
    chk("to_run_len", last_low_len, TO_CYC);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
